fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
// Read-side engine for the team's sync_fifo. Drives the FIFO read request,
// captures the FIFO's registered read data one cycle later, and presents it
// as a valid/ready stream with full 1-word/cycle throughput under
// back-pressure. Sits between a sync_fifo instance and any streaming consumer.
// PARAMETERS
// p_DATA_WIDTH   8  width of FIFO words and stream data
// p_LEVEL_WIDTH  9  width of FIFO occupancy input
// p_BUF_DEPTH    4  skid buffer entries, power of two, minimum 4
// PORTS
// i_CLK           in   1              clock, rising edge
// i_RST_N         in   1              asynchronous active-low reset
// i_FIFO_LEVEL    in   p_LEVEL_WIDTH  current FIFO occupancy, updated each edge
// i_FIFO_DATA     in   p_DATA_WIDTH   FIFO read data, valid 1 cycle after request
// o_READ_REQUEST  out  1              FIFO read strobe, one word per high cycle
// i_FLUSH         in   1              sync discard of buffered and in-flight data
// o_VALID         out  1              stream word available
// i_READY         in   1              consumer accepts o_DATA when o_VALID=1
// o_DATA          out  p_DATA_WIDTH   stream data, head of skid buffer
// o_BUF_LEVEL     out  $clog2(p_BUF_DEPTH)+1  words held in skid buffer
// BEHAVIOUR
// - Reset (i_RST_N=0, async): o_READ_REQUEST=0, o_VALID=0, o_DATA=0,
//   o_BUF_LEVEL=0, in-flight flag=0, buffer pointers=0. o_READ_REQUEST is
//   gated low combinationally while i_RST_N=0.
// - Read latency: request high in cycle n -> word on i_FIFO_DATA in n+1,
//   written into the buffer at the edge ending n+1; o_VALID high from n+2.
// - In-flight flag r_INFLIGHT <= o_READ_REQUEST each edge (unless flush).
// - o_READ_REQUEST = (i_FIFO_LEVEL != 0) && !i_FLUSH &&
//   (o_BUF_LEVEL + r_INFLIGHT < p_BUF_DEPTH). No dependence on i_READY.
// - i_FIFO_LEVEL already reflects the previous edge's read; never subtract
//   r_INFLIGHT from it. Never request when level is 0 (no underflow).
// - Capture: r_INFLIGHT=1 -> write i_FIFO_DATA at write pointer, wptr+1.
// - Pop: o_VALID && i_READY -> rptr+1. Capture and pop in the same cycle
//   leave o_BUF_LEVEL unchanged. Pointers wrap modulo p_BUF_DEPTH.
// - o_VALID = (o_BUF_LEVEL != 0); o_DATA = mem[rptr]. While o_VALID=1 and
//   i_READY=0, o_DATA holds stable. Words leave in FIFO order.
// - Credit rule guarantees a capture never finds the buffer full; sustained
//   i_READY=1 with level>0 gives one word per cycle after 2-cycle fill.
// - i_FLUSH=1 at an edge: pointers, o_BUF_LEVEL, r_INFLIGHT cleared; an
//   in-flight word arriving that cycle is dropped; no request in that cycle.
//   Words already in the FIFO are not affected. Flush wins over pop/capture.
// - Reset mid-burst: all state cleared immediately; the in-flight FIFO word is
//   lost (FIFO reset is the system's responsibility).
// - o_BUF_LEVEL arithmetic: next = cur + capture - pop, never exceeds depth.
// TESTING
// 1 Reset: hold i_RST_N=0 with level=5 -> o_READ_REQUEST=0, o_VALID=0,
//   o_DATA=0, o_BUF_LEVEL=0; release -> request in first cycle after.
// 2 Level 3, data 0xA1,0xB2,0xC3, i_READY=1 -> requests cycles 0-2, o_DATA
//   0xA1,0xB2,0xC3 in cycles 2-4, request low from cycle 3 (level 0).
// 3 Level 20, i_READY=0 -> exactly 4 requests, o_BUF_LEVEL=4, o_DATA holds
//   first word; raise i_READY -> 1 word/cycle, order intact, no gaps.
// 4 Level 0 for 50 cycles, ready toggling -> o_READ_REQUEST never high.
// 5 Buffer 2 words + 1 in flight, i_FLUSH pulse -> next cycle o_VALID=0,
//   o_BUF_LEVEL=0, in-flight word never appears on o_DATA.
// 6 Random level/ready, 10k cycles -> output sequence equals FIFO write
//   sequence, no request at level 0, o_BUF_LEVEL <= 4 always.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side engine for sync_fifo: issues read requests, captures the
// registered read data and re-presents it as a valid/ready stream.
module fifo_stream_reader #(
    parameter int p_DATA_WIDTH  = 8,
    parameter int p_LEVEL_WIDTH = 9,
    parameter int p_BUF_DEPTH   = 4
) (
    input  logic                             i_CLK,
    input  logic                             i_RST_N,
    input  logic [p_LEVEL_WIDTH-1:0]         i_FIFO_LEVEL,
    input  logic [p_DATA_WIDTH-1:0]          i_FIFO_DATA,
    output logic                             o_READ_REQUEST,
    input  logic                             i_FLUSH,
    output logic                             o_VALID,
    input  logic                             i_READY,
    output logic [p_DATA_WIDTH-1:0]          o_DATA,
    output logic [$clog2(p_BUF_DEPTH):0]     o_BUF_LEVEL
);

    localparam int c_PTR_W = $clog2(p_BUF_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W:0] c_DEPTH = (c_LVL_W + 1)'(p_BUF_DEPTH);

    logic [p_DATA_WIDTH-1:0] r_mem [p_BUF_DEPTH];
    logic [c_PTR_W-1:0]      r_wptr;
    logic [c_PTR_W-1:0]      r_rptr;
    logic [c_LVL_W-1:0]      r_level;
    logic                    r_inflight;

    logic                    w_capture;
    logic                    w_pop;
    logic [c_LVL_W:0]        w_committed;

    // Credit counts words held plus the one already requested.
    assign w_committed = {1'b0, r_level} + {{c_LVL_W{1'b0}}, r_inflight};

    assign o_READ_REQUEST = i_RST_N
                         && (i_FIFO_LEVEL != '0)
                         && !i_FLUSH
                         && (w_committed < c_DEPTH);

    assign w_capture   = r_inflight;
    assign o_VALID     = (r_level != '0);
    assign w_pop       = o_VALID && i_READY;
    assign o_DATA      = r_mem[r_rptr];
    assign o_BUF_LEVEL = r_level;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            for (int i = 0; i < p_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_inflight <= 1'b0;
        end else if (i_FLUSH) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= o_READ_REQUEST;
            if (w_capture) begin
                r_mem[r_wptr] <= i_FIFO_DATA;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_capture && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_capture && w_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and a
// scoreboard holds the words expected on the stream side.
module tb_fifo_stream_reader;

    logic       i_CLK = 1'b0;
    logic       i_RST_N;
    logic [8:0] i_FIFO_LEVEL;
    logic [7:0] i_FIFO_DATA;
    logic       o_READ_REQUEST;
    logic       i_FLUSH;
    logic       o_VALID;
    logic       i_READY;
    logic [7:0] o_DATA;
    logic [2:0] o_BUF_LEVEL;

    fifo_stream_reader #(
        .p_DATA_WIDTH (8),
        .p_LEVEL_WIDTH(9),
        .p_BUF_DEPTH  (4)
    ) dut (
        .i_CLK         (i_CLK),
        .i_RST_N       (i_RST_N),
        .i_FIFO_LEVEL  (i_FIFO_LEVEL),
        .i_FIFO_DATA   (i_FIFO_DATA),
        .o_READ_REQUEST(o_READ_REQUEST),
        .i_FLUSH       (i_FLUSH),
        .o_VALID       (o_VALID),
        .i_READY       (i_READY),
        .o_DATA        (o_DATA),
        .o_BUF_LEVEL   (o_BUF_LEVEL)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        logic [8:0] level;
        logic [7:0] data;
        logic       ready;
        logic       exp_req;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [2:0] exp_buf;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] sb[$];
    int         buf_m;
    bit         infl_m;
    int         n_req;
    int         n_pop;
    int         n_wr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_reset();
        i_RST_N      = 1'b0;
        i_FIFO_LEVEL = '0;
        i_FIFO_DATA  = '0;
        i_READY      = 1'b0;
        i_FLUSH      = 1'b0;
        fifo_q.delete();
        sb.delete();
        buf_m  = 0;
        infl_m = 0;
        repeat (2) @(posedge i_CLK);
        #1 i_RST_N = 1'b1;
    endtask

    // One clock with the FIFO model; entered and left at posedge+1.
    task automatic cycle(input logic rdy, input logic fl);
        logic       req, v, exp_req, do_rd, cap, pop;
        logic [7:0] d, e;
        logic [2:0] bl;
        i_READY      = rdy;
        i_FLUSH      = fl;
        i_FIFO_LEVEL = 9'(fifo_q.size());
        @(negedge i_CLK);
        req = o_READ_REQUEST;
        v   = o_VALID;
        d   = o_DATA;
        bl  = o_BUF_LEVEL;
        exp_req = (fifo_q.size() != 0) && !fl && (buf_m + int'(infl_m) < 4);
        chk("read_request", 32'(req), 32'(exp_req));
        chk("valid", 32'(v), 32'(buf_m != 0));
        chk("buf_level", 32'(bl), 32'(buf_m));
        if (bl > 3'd4) chk("buf_level_max", 32'(bl), 32'd4);
        if (v && rdy) begin
            e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            chk("data_order", 32'(d), 32'(e));
            n_pop++;
        end
        cap   = infl_m;
        pop   = (buf_m != 0) && rdy;
        do_rd = req && (fifo_q.size() != 0);
        if (do_rd) n_req++;
        @(posedge i_CLK);
        #1;
        if (fl) begin
            sb.delete();
            buf_m  = 0;
            infl_m = 0;
        end else begin
            buf_m  = buf_m + int'(cap) - int'(pop);
            infl_m = do_rd;
        end
        if (do_rd) begin
            e = fifo_q.pop_front();
            if (!fl) sb.push_back(e);
            i_FIFO_DATA = e;
        end else begin
            i_FIFO_DATA = 8'($urandom);
        end
        i_FIFO_LEVEL = 9'(fifo_q.size());
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(8'($urandom));
            n_wr++;
        end
    endtask

    vec_t vt[6];
    int   k;

    initial begin
        vt[0] = '{9'd3, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
        vt[1] = '{9'd2, 8'hA1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
        vt[2] = '{9'd1, 8'hB2, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd1};
        vt[3] = '{9'd0, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hB2, 3'd1};
        vt[4] = '{9'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC3, 3'd1};
        vt[5] = '{9'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};

        // Reset holds everything low even with words in the FIFO
        i_RST_N      = 1'b0;
        i_FIFO_LEVEL = 9'd5;
        i_FIFO_DATA  = 8'h5A;
        i_READY      = 1'b1;
        i_FLUSH      = 1'b0;
        repeat (2) @(negedge i_CLK);
        chk("rst_req", 32'(o_READ_REQUEST), 32'd0);
        chk("rst_valid", 32'(o_VALID), 32'd0);
        chk("rst_data", 32'(o_DATA), 32'd0);
        chk("rst_buf", 32'(o_BUF_LEVEL), 32'd0);
        @(posedge i_CLK);
        #1 i_RST_N = 1'b1;
        @(negedge i_CLK);
        chk("rel_req", 32'(o_READ_REQUEST), 32'd1);

        // Three-word burst from table
        do_reset();
        for (int i = 0; i < 6; i++) begin
            i_FIFO_LEVEL = vt[i].level;
            i_FIFO_DATA  = vt[i].data;
            i_READY      = vt[i].ready;
            @(negedge i_CLK);
            chk($sformatf("tbl%0d_req", i), 32'(o_READ_REQUEST),
                32'(vt[i].exp_req));
            chk($sformatf("tbl%0d_valid", i), 32'(o_VALID),
                32'(vt[i].exp_valid));
            chk($sformatf("tbl%0d_buf", i), 32'(o_BUF_LEVEL),
                32'(vt[i].exp_buf));
            if (vt[i].exp_valid)
                chk($sformatf("tbl%0d_data", i), 32'(o_DATA),
                    32'(vt[i].exp_data));
            @(posedge i_CLK);
            #1;
        end

        // Back-pressure fill then full-rate drain
        do_reset();
        load(20);
        n_req = 0;
        repeat (8) cycle(1'b0, 1'b0);
        chk("bp_requests", 32'(n_req), 32'd4);
        chk("bp_buf_level", 32'(o_BUF_LEVEL), 32'd4);
        chk("bp_head", 32'(o_DATA), 32'(sb[0]));
        n_pop = 0;
        k = 0;
        while (n_pop < 20 && k < 60) begin
            cycle(1'b1, 1'b0);
            k++;
        end
        chk("drain_cycles", 32'(k), 32'd20);

        // Empty FIFO never requested
        do_reset();
        n_req = 0;
        for (int i = 0; i < 50; i++) cycle(1'(i % 2), 1'b0);
        chk("empty_requests", 32'(n_req), 32'd0);

        // Flush with two buffered words and one in flight
        do_reset();
        load(10);
        repeat (3) cycle(1'b0, 1'b0);
        chk("pre_flush_buf", 32'(o_BUF_LEVEL), 32'd2);
        chk("pre_flush_infl", 32'(infl_m), 32'd1);
        cycle(1'b0, 1'b1);
        chk("post_flush_valid", 32'(o_VALID), 32'd0);
        chk("post_flush_buf", 32'(o_BUF_LEVEL), 32'd0);
        k = 0;
        while ((fifo_q.size() != 0 || sb.size() != 0) && k < 100) begin
            cycle(1'b1, 1'b0);
            k++;
        end
        chk("flush_drained", 32'(sb.size()), 32'd0);

        // Random level and back-pressure
        do_reset();
        n_wr  = 0;
        n_pop = 0;
        for (int i = 0; i < 10000; i++) begin
            if (fifo_q.size() < 200 && $urandom_range(0, 2) == 0)
                load($urandom_range(1, 3));
            cycle(1'($urandom_range(0, 1)), 1'b0);
        end
        k = 0;
        while ((fifo_q.size() != 0 || sb.size() != 0) && k < 2000) begin
            cycle(1'b1, 1'b0);
            k++;
        end
        chk("rand_drain_done", 32'(fifo_q.size() + sb.size()), 32'd0);
        chk("rand_word_count", 32'(n_pop), 32'(n_wr));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
